// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver with mid-bit sampling.
//
// The serial line rxd is oversampled at OVS x baud by sys_clk. A falling
// edge on the synchronized line starts a frame. The start bit is validated
// at its midpoint. Each data bit and the stop bit are then sampled one bit
// period apart. A frame with a good stop bit updates out_dat and pulses
// out_flag. A frame whose stop bit is low pulses frame_err and leaves
// out_dat untouched.
//
// Ports:
//   sys_clk   in   system clock, OVS x baud
//   rst       in   asynchronous active-high reset
//   rxd       in   serial input, asynchronous, idle high
//   out_dat   out  [7:0] last correctly framed byte
//   out_flag  out  one-cycle strobe: out_dat updated this cycle
//   frame_err out  one-cycle strobe: stop bit sampled low
//   busy      out  high while a frame is in progress
module uart_recv #(
    parameter int OVS = 16
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] out_dat,
    output logic       out_flag,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] MID     = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(OVS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        rxd_m_q, rxd_m_d;
    logic        rxd_s_q, rxd_s_d;
    logic        rxd_d_q, rxd_d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  out_dat_q, out_dat_d;
    logic        out_flag_q, out_flag_d;
    logic        frame_err_q, frame_err_d;

    // Two-flop synchronizer, plus one delay flop for falling-edge detection.
    always_comb begin
        rxd_m_d = rxd;
        rxd_s_d = rxd_m_q;
        rxd_d_d = rxd_s_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        out_dat_d   = out_dat_q;
        out_flag_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                // A line held low (e.g. break) never looks like a new edge.
                if (rxd_d_q && !rxd_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == MID) begin
                    if (!rxd_s_q) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                // OVS is a power of two, so the counter wraps on its own.
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_MAX) begin
                    shreg_d = {rxd_s_q, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + CW'(1);
                // Leaving at mid stop bit leaves half a bit to catch a
                // back-to-back start edge.
                if (cnt_q == CNT_MAX) begin
                    if (rxd_s_q) begin
                        out_dat_d  = shreg_q;
                        out_flag_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rxd_m_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            rxd_d_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            out_dat_q   <= 8'h00;
            out_flag_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rxd_m_q     <= rxd_m_d;
            rxd_s_q     <= rxd_s_d;
            rxd_d_q     <= rxd_d_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            out_dat_q   <= out_dat_d;
            out_flag_q  <= out_flag_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Shift register is pure data; its contents only matter after 8 shifts.
    always_ff @(posedge sys_clk) begin
        shreg_q <= shreg_d;
    end

    assign out_dat   = out_dat_q;
    assign out_flag  = out_flag_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/uart_recv.md
# uart_recv

UART receiver and the receive-side counterpart of the transmitter. It accepts an asynchronous 8N1 serial line (1 start bit, 8 data bits sent LSB first, 1 stop bit, no parity) clocked by `sys_clk` running at OVS × baud. It recovers each byte by mid-bit sampling and presents it with a single-cycle strobe. Framing errors and false starts are reported or rejected without disturbing the last good byte.

## Interface
- `OVS`, default 16: oversampling ratio (`sys_clk` / baud). Power of two, ≥ 4. Mid-bit point `MID` = OVS/2 − 1.

- `sys_clk`  in  1  system clock, OVS × baud
- `rst`  in  1  reset; one clock, asynchronous, active-high
- `rxd`  in  1  serial input, asynchronous to `sys_clk`, idle high
- `out_dat`  out  8  last correctly framed byte; held until the next good frame
- `out_flag`  out  1  one-cycle pulse: `out_dat` updated this cycle
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE)

## Operation
- `rxd` passes through a 2-flop synchronizer into `rxd_s`. A third flop holds `rxd_d` (`rxd_s` delayed by one cycle) for edge detection. All three reset to 1.
- Counters:
  - `cnt`: log2(OVS) bits; its reset value is 0.
  - `bit_idx`: 3 bits.
  - `shreg`: 8 bits, filled by shifting right with the new bit entering at bit 7. After 8 shifts, bit 0 holds the first bit received.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: on `rxd_d`=1 and `rxd_s`=0 → START, `cnt`←0.
  - START: `cnt` increments each cycle. When `cnt`==MID:
    - `rxd_s`=0 → DATA, `cnt`←0, `bit_idx`←0.
    - `rxd_s`=1 → IDLE (glitch rejected, no outputs).
  - DATA: `cnt` increments and wraps at OVS−1. When `cnt`==OVS−1, sample `rxd_s` into `shreg`.
    - If `bit_idx`==7 → STOP. Otherwise `bit_idx`+1.
  - STOP: when `cnt`==OVS−1, sample `rxd_s`.
    - 1 → `out_dat`←`shreg`, `out_flag`←1.
    - 0 → `frame_err`←1, `out_dat` unchanged.
    - Both cases → IDLE.
- Leaving STOP at mid stop bit lets a back-to-back start edge be caught with half a bit of margin.
- After a framing error (for example a break), a new frame needs `rxd` to return high and then fall again. No start is detected while the line stays low.
- `out_flag` and `frame_err` are registered, never high together, and high for exactly one cycle per frame.
- `busy` is combinational from the state: 1 in START/DATA/STOP.
- Reset values: `out_dat`=0x00, `out_flag`=0, `frame_err`=0, `busy`=0, state=IDLE.
- Reset mid-frame aborts the frame with no strobe. Reception restarts only on a fresh falling edge after reset is released.

## Timing
- Pin to `rxd_s`: 2 cycles. `rxd_s` to edge detect: 1 cycle.
- Let E be the clock edge where IDLE→START is taken. Relative to E:
  - Start validated at E+OVS/2.
  - Data bit n (n = 0…7) sampled at E+OVS/2+OVS·(n+1).
  - Stop bit sampled at E+OVS/2+9·OVS.
- For OVS=16: start validated at E+8, bit0 at E+24, bit7 at E+136, stop at E+152.
- `out_flag` or `frame_err` is high in the cycle following edge E+152. `out_dat` is valid in that same cycle.
- Baud tolerance: the sample point stays inside the bit as long as cumulative drift is less than ±(OVS/2−1) cycles over 9.5 bits, which is about ±4.6 % at OVS=16.

## Test plan
- Single frame 0x55 driven at 16 clk/bit from idle → one `out_flag` pulse 152 cycles after E (≈155 after the pin falls); `out_dat`=0x55; `frame_err` stays 0; `busy` high for the whole frame.
- Back-to-back 0xA3 then 0x3C with a 1-bit stop and no idle gap → two `out_flag` pulses; `out_dat`=0xA3, then 0x3C; no errors.
- 4-cycle low glitch on an idle line → `busy` rises for 8 cycles, then returns to IDLE; no `out_flag`, no `frame_err`, `out_dat` unchanged.
- Frame 0xF0 with the stop bit driven low → `frame_err` pulses once, `out_flag` stays 0, `out_dat` keeps the previous 0x3C.
  - Line then held low for 40 bits → no further events.
  - Line released and frame 0x81 sent → `out_dat`=0x81.
- `rst` pulsed during data bit 4 of 0x7E → all outputs return to reset values immediately; no strobe for the aborted frame.
  - The next clean frame 0x12 sent after reset is released is received correctly.
